dma_write_engine: RTL and testbench
===================================

Name: dma_write_engine

Overview:
- Destination-side DMA stage that sits directly downstream of the 32-bit transfer FIFO.
- Once started, it pops words from the FIFO and issues single-beat writes to the destination memory port using a valid/ready handshake.
- The address increments one word per beat; a one-cycle done pulse marks the end of the programmed length.
- Words are moved strictly in FIFO order; there is no buffering beyond one holding register.

Parameters:
- DATA_WIDTH, 32, width of FIFO data and memory write data.
- ADDR_WIDTH, 32, width of the destination byte address.
- LEN_WIDTH, 16, width of the transfer length, counted in words.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a transfer; ignored while busy=1.
- dst_addr  input  ADDR_WIDTH  start byte address, sampled when start is accepted.
- xfer_len  input  LEN_WIDTH  number of words, sampled when start is accepted.
- abort  input  1  request to terminate the current transfer.
- fifo_dout  input  DATA_WIDTH  FIFO read data; valid the cycle after fifo_read_en.
- fifo_empty  input  1  FIFO empty flag.
- fifo_read_en  output  1  FIFO pop strobe.
- mem_addr  output  ADDR_WIDTH  write address.
- mem_wdata  output  DATA_WIDTH  write data.
- mem_wvalid  output  1  write request valid.
- mem_wready  input  1  destination accepts the beat.
- busy  output  1  high from start acceptance until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.
- aborted  output  1  one-cycle pulse on abort completion.
- words_done  output  LEN_WIDTH  count of beats accepted in the current or last transfer.

Behaviour:
- Reset: state=IDLE. All outputs are 0: fifo_read_en, mem_addr, mem_wdata, mem_wvalid, busy, done, aborted and words_done. Internal addr/remaining registers are cleared. Reset asserted mid-transfer abandons the transfer immediately with no pulse.
- States:
  - IDLE: start=1 latches dst_addr into the addr register and xfer_len into remaining. It also clears words_done and sets busy=1.
    - xfer_len=0 goes to DONE; otherwise go to POP.
  - POP: fifo_read_en = (state==POP && !fifo_empty && !abort), driven combinationally.
    - If fifo_read_en=1, go to LATCH.
    - If fifo_empty, stay in POP and wait indefinitely.
  - LATCH: capture fifo_dout into mem_wdata and drive mem_addr=addr. Set mem_wvalid=1 and go to WRITE.
  - WRITE: mem_wvalid, mem_addr and mem_wdata are held stable until mem_wready=1.
    - On handshake (wvalid&&wready) at the clock edge:
      - mem_wvalid drops next cycle.
      - addr += DATA_WIDTH/8, wrapping modulo 2^ADDR_WIDTH.
      - remaining -= 1 and words_done += 1.
    - After the handshake: if remaining was 1, go to DONE; else if abort is pending, go to ABORT; else go to POP.
  - DONE: done=1 for exactly one cycle, busy=0 in the same cycle, then return to IDLE.
  - ABORT: aborted=1 for exactly one cycle, busy=0, then return to IDLE.
- Abort:
  - Sampled in POP: go directly to ABORT, with no FIFO pop in that cycle.
  - Sampled in LATCH or WRITE: latched into an abort_pending flag.
  - Pending abort from LATCH: the popped word is still written before the engine goes to ABORT. A beat already in flight always completes, and wvalid never drops without wready.
  - abort in IDLE has no effect.
  - If abort arrives on the last beat, done takes priority over aborted.
- Latency:
  - start to first fifo_read_en is 1 cycle, if the FIFO is non-empty.
  - fifo_read_en to mem_wvalid is 2 cycles.
  - Best-case throughput is one word per 3 cycles, with wready held high.
- start while busy is ignored: no relatch, no effect on the current transfer.
- start is accepted in the same cycle the engine is in IDLE.
- words_done holds its final value after DONE/ABORT until the next accepted start.
- xfer_len uses the full range. The maximum 2^LEN_WIDTH-1 words must not overflow remaining or words_done.
- fifo_read_en is never asserted while fifo_empty=1 or while any write is outstanding.

Test Plan:
- Reset, then start with dst_addr=0x1000, xfer_len=4; FIFO preloaded with 0xA0..0xA3; wready tied 1. Required response:
  - Writes occur to 0x1000/0x1004/0x1008/0x100C with data 0xA0..0xA3.
  - done pulses once; words_done=4; busy falls with done.
- wready held low 5 cycles on beat 2. Required response: mem_addr, mem_wdata and mem_wvalid stay stable for all 5 cycles; there is no extra pop and no data loss.
- FIFO empty for 10 cycles mid-transfer (len=3). Required response: the engine waits in POP with fifo_read_en=0, resumes when data arrives, and ends with words_done=3.
- xfer_len=0. Required response: done pulses 2 cycles after start, with no fifo_read_en and no mem_wvalid.
- abort asserted during WRITE of beat 2 of 8. Required response: beat 2 completes, then aborted pulses. done stays 0, words_done=2, and there are no further pops.
- dst_addr=0xFFFFFFFC, len=2. Required response: second write goes to 0x00000000.
- start pulsed while busy: ignored.
- rst asserted mid-WRITE: all outputs are 0 immediately, asynchronously.

Source files
------------

// File: rtl/dma_write_engine.sv
// Pops 32-bit words from the transfer FIFO and issues single-beat memory writes at incrementing addresses.
// Three cycles per word best case (pop, latch, write); a stalled write holds addr/data/valid until wready.
module dma_write_engine #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  xfer_len,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_read_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [LEN_WIDTH-1:0]  words_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LATCH,
        S_WRITE,
        S_DONE,
        S_ABORT
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(DATA_WIDTH / 8);
    localparam logic [LEN_WIDTH-1:0]  LEN_ONE   = LEN_WIDTH'(1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic                  abort_pending;
    logic                  beat_accepted;

    // An abort seen in POP suppresses the pop in that same cycle.
    assign fifo_read_en  = (state == S_POP) && !fifo_empty && !abort;
    assign beat_accepted = mem_wvalid && mem_wready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            addr          <= '0;
            remaining     <= '0;
            abort_pending <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            mem_wvalid    <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            aborted       <= 1'b0;
            words_done    <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        addr          <= dst_addr;
                        remaining     <= xfer_len;
                        words_done    <= '0;
                        abort_pending <= 1'b0;
                        busy          <= 1'b1;
                        state         <= (xfer_len == '0) ? S_DONE : S_POP;
                    end
                end
                S_POP: begin
                    if (abort) begin
                        state <= S_ABORT;
                    end else if (!fifo_empty) begin
                        state <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    mem_wdata  <= fifo_dout;
                    mem_addr   <= addr;
                    mem_wvalid <= 1'b1;
                    if (abort) begin
                        abort_pending <= 1'b1;
                    end
                    state <= S_WRITE;
                end
                S_WRITE: begin
                    if (abort) begin
                        abort_pending <= 1'b1;
                    end
                    // The last beat finishes as done even when an abort is outstanding.
                    if (beat_accepted) begin
                        mem_wvalid <= 1'b0;
                        addr       <= addr + ADDR_STEP;
                        remaining  <= remaining - LEN_ONE;
                        words_done <= words_done + LEN_ONE;
                        if (remaining == LEN_ONE) begin
                            state <= S_DONE;
                        end else if (abort_pending || abort) begin
                            state <= S_ABORT;
                        end else begin
                            state <= S_POP;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ABORT: begin
                    aborted <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: behavioural FIFO, beat scoreboard and per-scenario tasks.
module tb_dma_write_engine;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int LW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] dst_addr = '0;
    logic [LW-1:0] xfer_len = '0;
    logic          abort = 1'b0;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_read_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_wvalid;
    logic          mem_wready = 1'b1;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [LW-1:0] words_done;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0]    fifo_q[$];
    logic [AW+DW-1:0] exp_q[$];
    logic [AW+DW-1:0] obs_q[$];

    int cyc = 0;
    int pops = 0, underflow = 0;
    int rd_cnt = 0, wv_cnt = 0, stall_cnt = 0, done_cnt = 0, abort_cnt = 0, viol = 0;
    int first_rd_cyc = -1, first_wv_cyc = -1, done_cyc = -1, start_cyc = 0;
    logic             prev_stall = 1'b0;
    logic [AW+DW-1:0] prev_beat = '0;

    dma_write_engine #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .dst_addr(dst_addr), .xfer_len(xfer_len),
        .abort(abort), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
        .fifo_read_en(fifo_read_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .busy(busy), .done(done),
        .aborted(aborted), .words_done(words_done)
    );

    always #5 clk = ~clk;

    // FIFO model: data appears the cycle after the pop strobe.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (fifo_read_en && !rst) begin
            pops = pops + 1;
            if (fifo_q.size() > 0) fifo_dout <= fifo_q.pop_front();
            else underflow = underflow + 1;
        end
    end

    always begin
        @(posedge clk);
        #2;
        fifo_empty = (fifo_q.size() == 0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (fifo_read_en) begin
                rd_cnt = rd_cnt + 1;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
                if (fifo_empty || mem_wvalid) viol = viol + 1;
            end
            if (mem_wvalid) begin
                wv_cnt = wv_cnt + 1;
                if (first_wv_cyc < 0) first_wv_cyc = cyc;
            end
            if (prev_stall && (!mem_wvalid || {mem_addr, mem_wdata} !== prev_beat)) viol = viol + 1;
            if (mem_wvalid && !mem_wready) stall_cnt = stall_cnt + 1;
            if (mem_wvalid && mem_wready) obs_q.push_back({mem_addr, mem_wdata});
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
                if (busy) viol = viol + 1;
            end
            if (aborted) begin
                abort_cnt = abort_cnt + 1;
                if (busy) viol = viol + 1;
            end
            prev_stall = mem_wvalid && !mem_wready;
            prev_beat  = {mem_addr, mem_wdata};
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic clear_stats();
        pops = 0; underflow = 0; rd_cnt = 0; wv_cnt = 0; stall_cnt = 0;
        done_cnt = 0; abort_cnt = 0; viol = 0;
        first_rd_cyc = -1; first_wv_cyc = -1; done_cyc = -1;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic load_words(input logic [AW-1:0] base, input logic [DW-1:0] d0,
                              input int n, input int n_exp);
        logic [AW-1:0] a;
        for (int i = 0; i < n; i++) begin
            fifo_q.push_back(d0 + DW'(i));
            a = base + AW'(4 * i);
            if (i < n_exp) exp_q.push_back({a, d0 + DW'(i)});
        end
    endtask

    task automatic start_xfer(input logic [AW-1:0] a, input logic [LW-1:0] len);
        @(posedge clk); #1;
        start = 1'b1; dst_addr = a; xfer_len = len; start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit to);
        int base;
        base = done_cnt + abort_cnt;
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_cnt + abort_cnt > base) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_wvalid(input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (mem_wvalid) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic wait_beats(input int n, input int budget, output bit to);
        to = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (obs_q.size() >= n) begin
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (fifo_read_en !== 1'b0) begin failures++; $display("FAIL reset_read_en got=%b exp=0", fifo_read_en); end
        checks++; if (mem_addr !== '0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
        checks++; if (mem_wdata !== '0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0", mem_wdata); end
        checks++; if (mem_wvalid !== 1'b0) begin failures++; $display("FAIL reset_wvalid got=%b exp=0", mem_wvalid); end
        checks++; if ({busy, done, aborted} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {busy, done, aborted}); end
        checks++; if (words_done !== '0) begin failures++; $display("FAIL reset_words_done got=%0d exp=0", words_done); end
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        bit to;
        logic [AW+DW-1:0] e, o;
        clear_stats();
        mem_wready = 1'b1;
        load_words(32'h1000, 32'hA0, 4, 4);
        start_xfer(32'h1000, 16'd4);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", busy); end
        wait_end(100, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=timeout exp=done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin failures++; $display("FAIL basic_beat got=%h exp=%h", o, e); end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL basic_extra_beats got=%0d exp=0", obs_q.size()); end
        checks++; if (done_cnt !== 1 || abort_cnt !== 0) begin failures++; $display("FAIL basic_pulses got=%0d/%0d exp=1/0", done_cnt, abort_cnt); end
        checks++; if (words_done !== 16'd4) begin failures++; $display("FAIL basic_words_done got=%0d exp=4", words_done); end
        checks++; if (first_rd_cyc - start_cyc !== 1) begin failures++; $display("FAIL basic_start_to_pop got=%0d exp=1", first_rd_cyc - start_cyc); end
        checks++; if (first_wv_cyc - first_rd_cyc !== 2) begin failures++; $display("FAIL basic_pop_to_wvalid got=%0d exp=2", first_wv_cyc - first_rd_cyc); end
        checks++; if (done_cyc - start_cyc !== 14) begin failures++; $display("FAIL basic_throughput got=%0d exp=14", done_cyc - start_cyc); end
        checks++; if (viol !== 0 || underflow !== 0) begin failures++; $display("FAIL basic_protocol got=%0d/%0d exp=0/0", viol, underflow); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_stall();
        bit to;
        logic [AW+DW-1:0] e, o;
        clear_stats();
        mem_wready = 1'b1;
        load_words(32'h2000, 32'hB0, 4, 4);
        start_xfer(32'h2000, 16'd4);
        wait_beats(1, 50, to);
        mem_wready = 1'b0;
        wait_wvalid(50, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL stall_wvalid_timeout got=timeout exp=wvalid"); end
        repeat (5) @(posedge clk);
        #1;
        mem_wready = 1'b1;
        wait_end(100, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL stall_timeout got=timeout exp=done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin failures++; $display("FAIL stall_beat got=%h exp=%h", o, e); end
        end
        checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", stall_cnt); end
        checks++; if (pops !== 4) begin failures++; $display("FAIL stall_pops got=%0d exp=4", pops); end
        checks++; if (viol !== 0) begin failures++; $display("FAIL stall_stability got=%0d exp=0", viol); end
        checks++; if (words_done !== 16'd4) begin failures++; $display("FAIL stall_words_done got=%0d exp=4", words_done); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_empty();
        bit to;
        int rd_before;
        logic [AW+DW-1:0] e, o;
        clear_stats();
        load_words(32'h3000, 32'hC0, 1, 1);
        start_xfer(32'h3000, 16'd3);
        wait_beats(1, 50, to);
        rd_before = rd_cnt;
        repeat (10) @(posedge clk);
        #1;
        checks++; if (rd_cnt !== rd_before || fifo_read_en !== 1'b0) begin failures++; $display("FAIL empty_no_pop got=%0d exp=%0d", rd_cnt, rd_before); end
        checks++; if (busy !== 1'b1 || mem_wvalid !== 1'b0) begin failures++; $display("FAIL empty_waiting got=%b%b exp=10", busy, mem_wvalid); end
        load_words(32'h3004, 32'hC1, 2, 2);
        wait_end(100, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL empty_timeout got=timeout exp=done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin failures++; $display("FAIL empty_beat got=%h exp=%h", o, e); end
        end
        checks++; if (words_done !== 16'd3) begin failures++; $display("FAIL empty_words_done got=%0d exp=3", words_done); end
        checks++; if (viol !== 0 || underflow !== 0) begin failures++; $display("FAIL empty_protocol got=%0d/%0d exp=0/0", viol, underflow); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_zero_len();
        bit to;
        clear_stats();
        start_xfer(32'h8000, 16'd0);
        wait_end(20, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL zero_timeout got=timeout exp=done"); end
        checks++; if (done_cyc - start_cyc !== 2) begin failures++; $display("FAIL zero_done_latency got=%0d exp=2", done_cyc - start_cyc); end
        checks++; if (rd_cnt !== 0 || wv_cnt !== 0) begin failures++; $display("FAIL zero_activity got=%0d/%0d exp=0/0", rd_cnt, wv_cnt); end
        checks++; if (words_done !== 16'd0) begin failures++; $display("FAIL zero_words_done got=%0d exp=0", words_done); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort();
        bit to;
        logic [AW+DW-1:0] e, o;
        clear_stats();
        mem_wready = 1'b1;
        load_words(32'h4000, 32'hD0, 8, 2);
        start_xfer(32'h4000, 16'd8);
        wait_beats(1, 50, to);
        mem_wready = 1'b0;
        wait_wvalid(50, to);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        mem_wready = 1'b1;
        wait_end(50, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL abort_timeout got=timeout exp=aborted"); end
        repeat (10) @(posedge clk);
        #1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin failures++; $display("FAIL abort_beat got=%h exp=%h", o, e); end
        end
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL abort_extra_beats got=%0d exp=0", obs_q.size()); end
        checks++; if (abort_cnt !== 1 || done_cnt !== 0) begin failures++; $display("FAIL abort_pulses got=%0d/%0d exp=1/0", abort_cnt, done_cnt); end
        checks++; if (words_done !== 16'd2) begin failures++; $display("FAIL abort_words_done got=%0d exp=2", words_done); end
        checks++; if (pops !== 2) begin failures++; $display("FAIL abort_pops got=%0d exp=2", pops); end
        fifo_q.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic test_abort_last();
        bit to;
        clear_stats();
        mem_wready = 1'b0;
        load_words(32'h6000, 32'hF0, 1, 1);
        start_xfer(32'h6000, 16'd1);
        wait_wvalid(50, to);
        abort = 1'b1;
        @(posedge clk); #1;
        mem_wready = 1'b1;
        wait_end(50, to);
        abort = 1'b0;
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL abort_last_timeout got=timeout exp=done"); end
        checks++; if (done_cnt !== 1 || abort_cnt !== 0) begin failures++; $display("FAIL abort_last_priority got=%0d/%0d exp=1/0", done_cnt, abort_cnt); end
        checks++; if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin failures++; $display("FAIL abort_last_beat got=%0d beats exp=1", obs_q.size()); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_wrap();
        bit to;
        logic [AW+DW-1:0] e, o;
        clear_stats();
        mem_wready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        load_words(32'hFFFF_FFFC, 32'hE0, 2, 2);
        start_xfer(32'hFFFF_FFFC, 16'd2);
        wait_end(50, to);
        checks++; if (to !== 1'b0 || done_cnt !== 1 || abort_cnt !== 0) begin failures++; $display("FAIL wrap_end got=%0d/%0d exp=1/0", done_cnt, abort_cnt); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin failures++; $display("FAIL wrap_beat got=%h exp=%h", o, e); end
        end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_start_busy();
        bit to;
        logic [AW+DW-1:0] e, o;
        clear_stats();
        load_words(32'h5000, 32'h51, 3, 3);
        start_xfer(32'h5000, 16'd3);
        @(posedge clk); #1;
        start = 1'b1; dst_addr = 32'h9000; xfer_len = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_end(100, to);
        checks++; if (to !== 1'b0) begin failures++; $display("FAIL busy_start_timeout got=timeout exp=done"); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            checks++; if (o !== e) begin failures++; $display("FAIL busy_start_beat got=%h exp=%h", o, e); end
        end
        checks++; if (words_done !== 16'd3 || done_cnt !== 1) begin failures++; $display("FAIL busy_start_result got=%0d/%0d exp=3/1", words_done, done_cnt); end
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_stats();
        mem_wready = 1'b0;
        load_words(32'h7000, 32'h70, 4, 0);
        start_xfer(32'h7000, 16'd4);
        wait_wvalid(50, to);
        #2;
        rst = 1'b1;
        #1;
        checks++; if (mem_wvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL rst_mid_ctrl got=%b%b exp=00", mem_wvalid, busy); end
        checks++; if (mem_addr !== '0 || mem_wdata !== '0) begin failures++; $display("FAIL rst_mid_bus got=%h/%h exp=0/0", mem_addr, mem_wdata); end
        checks++; if (fifo_read_en !== 1'b0 || words_done !== '0) begin failures++; $display("FAIL rst_mid_misc got=%b/%0d exp=0/0", fifo_read_en, words_done); end
        @(posedge clk); #1;
        rst = 1'b0;
        mem_wready = 1'b1;
        fifo_q.delete();
        repeat (10) @(posedge clk);
        #1;
        checks++; if (done_cnt !== 0 || abort_cnt !== 0) begin failures++; $display("FAIL rst_mid_pulse got=%0d/%0d exp=0/0", done_cnt, abort_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_empty();
        test_zero_len();
        test_abort();
        test_abort_last();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
